pipe_debug_responder: RTL and testbench
=======================================

Name: pipe_debug_responder

Overview:
- Hardware debug responder for the pipelined processor. It is the in-silicon counterpart of the bench's hierarchical peeks at PC and register file.
- Accepts commands from an external debug master over a valid/ready request channel: halt, resume, single-step, read register, read PC.
- Returns results on a valid/ready response channel.
- Sits beside Top_pipline: holds instruction fetch, lets the 5-stage pipe drain, then reads architectural state through a dedicated register-file read port.

Parameters:
- DRAIN_CYCLES, 5, cycles of fetch hold before the pipe is considered empty (one per stage).
- DATA_W, 32, width of PC, register and response data.
- RF_AW, 5, register-file address width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  debug command present
- req_ready  out  1  responder can accept a command
- req_cmd  in  3  000 HALT, 001 RESUME, 010 STEP, 011 READ_REG, 100 READ_PC, 101 READ_CYCLE (optional feature only), others illegal
- req_addr  in  RF_AW  register index for READ_REG
- resp_valid  out  1  response present
- resp_ready  in  1  master accepts response
- resp_data  out  DATA_W  read data; 0 for non-read commands and errors
- resp_err  out  1  command illegal or not permitted in current state
- fetch_hold  out  1  to IF stage: stop fetching, inject bubbles, hold PC
- rf_raddr  out  RF_AW  debug read address into register file
- rf_rdata  in  DATA_W  combinational register-file read data
- pc_i  in  DATA_W  current program_counter

Behaviour:
- Reset, clk edge with reset_n=0:
  - state=RUN; req_ready=1; resp_valid=0; resp_data=0; resp_err=0; fetch_hold=0; rf_raddr=0; drain counter=0.
  - Reset wins over any in-flight command. A pending response is dropped.
- Handshake:
  - Request accepted when req_valid && req_ready.
  - Response completes when resp_valid && resp_ready.
  - req_ready=0 from acceptance until the response completes: exactly one command outstanding.
  - resp_valid, resp_data and resp_err stay stable while resp_ready=0.
- States:
  - RUN, DRAIN, HALTED, STEP_REL, RDREG, RESP.
  - A `halted` flag records the architectural state the response returns to: RUN or HALTED.
- HALT in RUN: fetch_hold=1 the cycle after acceptance → DRAIN. Count DRAIN_CYCLES cycles → HALTED, then response (data 0, err 0).
- HALT in HALTED: immediate response, err 0; idempotent.
- RESUME:
  - In HALTED: fetch_hold=0 the cycle after acceptance, response err 0, return to RUN.
  - In RUN: response err 0, no effect.
- STEP in HALTED:
  - STEP_REL: fetch_hold=0 for exactly one cycle, so exactly one instruction is fetched.
  - Then fetch_hold=1 → DRAIN (DRAIN_CYCLES) → HALTED → response with resp_data = pc_i after the drain.
- STEP in RUN: response err 1.
- READ_REG, halted only:
  - Acceptance cycle T: rf_raddr=req_addr registered at T+1 (state RDREG).
  - rf_rdata captured at T+2 edge; resp_valid=1 from T+2.
  - Index 0 returns rf_rdata unmodified; the register file guarantees 0.
- READ_PC, halted only: resp_data=pc_i captured at acceptance+1; resp_valid from acceptance+1.
- Read in RUN: resp_err=1, resp_data=0, no state change.
- Illegal cmd, any state: resp_err=1, resp_data=0, no state change.
- Simultaneous response completion and new req_valid: new request not accepted until the cycle after completion (req_ready rises then).
- fetch_hold never toggles while in DRAIN. Drain counter saturates at DRAIN_CYCLES.

Optional Feature:
- Macro: PIPE_DEBUG_CYCLE_COUNTER_EN.
- Defined:
  - Free-running 32-bit cycle counter; reset to 0, +1 every clk, wraps 0xFFFFFFFF→0.
  - Counter freezes while halted (fetch_hold=1 and state HALTED).
  - READ_CYCLE legal in any state. Returns counter value at acceptance, latency 1.
- Undefined: no counter logic; READ_CYCLE treated as illegal (err 1, data 0).

Test Plan:
- Reset with req_valid=1 → req_ready=1, resp_valid=0, fetch_hold=0, no command accepted until reset_n=1.
- Program from PC 100 runs; HALT after 14 cycles → fetch_hold=1 next cycle, response after 5 drain cycles, err 0.
- READ_REG 8..15 → resp_data 4,8,12,16,20,24,28,32. Each response at acceptance+2.
- While halted, READ_PC → stable pc_i. STEP → exactly one fetch cycle, response PC = previous+4. Then RESUME → fetch_hold=0.
- READ_REG in RUN, and cmd 111 → err 1, data 0, state unchanged. With resp_ready=0 for 3 cycles, response held stable and req_ready stays 0.
- Macro defined: READ_CYCLE twice 10 cycles apart in RUN → difference 10; while halted, difference 0. Macro undefined: READ_CYCLE → err 1.

Source files
------------

// File: rtl/pipe_debug_responder.sv
// pipe_debug_responder: in-silicon debug responder for the 5-stage pipeline.
// It accepts halt/resume/step/read commands over a valid/ready request
// channel, holds instruction fetch and lets the pipe drain before it reads
// architectural state, and returns one response per command over a
// valid/ready response channel.
// Optional feature: define PIPE_DEBUG_CYCLE_COUNTER_EN to add a 32-bit cycle
// counter and the READ_CYCLE command. When it is undefined, READ_CYCLE is illegal.
module pipe_debug_responder #(
  parameter int DRAIN_CYCLES = 5,
  parameter int DATA_W       = 32,
  parameter int RF_AW        = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_cmd,
  input  logic [RF_AW-1:0]  req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              fetch_hold,
  output logic [RF_AW-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic [DATA_W-1:0] pc_i
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_MAX  = CNT_W'(DRAIN_CYCLES);

  localparam logic [2:0] CMD_HALT       = 3'b000;
  localparam logic [2:0] CMD_RESUME     = 3'b001;
  localparam logic [2:0] CMD_STEP       = 3'b010;
  localparam logic [2:0] CMD_READ_REG   = 3'b011;
  localparam logic [2:0] CMD_READ_PC    = 3'b100;
`ifdef PIPE_DEBUG_CYCLE_COUNTER_EN
  localparam logic [2:0] CMD_READ_CYCLE = 3'b101;
`endif

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED,
    ST_STEP_REL,
    ST_RDREG,
    ST_RESP
  } state_t;

  state_t           state;
  logic             halted;        // architectural state the response returns to
  logic             step_pending;  // current drain belongs to a STEP, not a HALT
  logic [CNT_W-1:0] drain_cnt;

`ifdef PIPE_DEBUG_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  // Free-running cycle counter, frozen while the core is halted with fetch held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
    end else if (!(halted && fetch_hold)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  // Command FSM: handles acceptance, drain sequencing and response hold.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments. A later assignment
    // in the same pass overrides an earlier default, so defaults come first.
    if (!reset_n) begin
      state        <= ST_RUN;
      halted       <= 1'b0;
      step_pending <= 1'b0;
      drain_cnt    <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      fetch_hold   <= 1'b0;
      rf_raddr     <= '0;
    end else begin
      unique case (state)
        ST_RUN, ST_HALTED: begin
          if (req_valid && req_ready) begin
            // Default: answer next cycle with data 0 and no error.
            req_ready  <= 1'b0;
            resp_valid <= 1'b1;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            state      <= ST_RESP;
            case (req_cmd)
              CMD_HALT: begin
                if (!halted) begin
                  resp_valid   <= 1'b0;
                  fetch_hold   <= 1'b1;
                  drain_cnt    <= '0;
                  step_pending <= 1'b0;
                  state        <= ST_DRAIN;
                end
              end
              CMD_RESUME: begin
                if (halted) begin
                  fetch_hold <= 1'b0;
                  halted     <= 1'b0;
                end
              end
              CMD_STEP: begin
                if (halted) begin
                  resp_valid   <= 1'b0;
                  fetch_hold   <= 1'b0;
                  step_pending <= 1'b1;
                  state        <= ST_STEP_REL;
                end else begin
                  resp_err <= 1'b1;
                end
              end
              CMD_READ_REG: begin
                if (halted) begin
                  resp_valid <= 1'b0;
                  rf_raddr   <= req_addr;
                  state      <= ST_RDREG;
                end else begin
                  resp_err <= 1'b1;
                end
              end
              CMD_READ_PC: begin
                if (halted) resp_data <= pc_i;
                else        resp_err  <= 1'b1;
              end
`ifdef PIPE_DEBUG_CYCLE_COUNTER_EN
              CMD_READ_CYCLE: resp_data <= DATA_W'(cycle_cnt);
`endif
              default: resp_err <= 1'b1;
            endcase
          end
        end
        ST_STEP_REL: begin
          // Fetch was released for exactly one cycle; clamp it again and drain.
          fetch_hold <= 1'b1;
          drain_cnt  <= '0;
          state      <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_cnt != DRAIN_MAX) drain_cnt <= drain_cnt + CNT_W'(1);
          if (drain_cnt == DRAIN_LAST) begin
            halted     <= 1'b1;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= step_pending ? pc_i : '0;
            state      <= ST_RESP;
          end
        end
        ST_RDREG: begin
          resp_data  <= rf_rdata;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          // Response held stable until taken; the next request is admitted a cycle later.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= halted ? ST_HALTED : ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_debug_responder.sv
// Directed bench for pipe_debug_responder with a small PC / register-file model.
module tb_pipe_debug_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = 3'd0;
  logic [4:0]  req_addr = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        fetch_hold;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] pc = 32'd0;
  logic [31:0] rf [32];

  int n_checks = 0;
  int n_err    = 0;

  pipe_debug_responder #(.DRAIN_CYCLES(5), .DATA_W(32), .RF_AW(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .fetch_hold (fetch_hold),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .pc_i       (pc)
  );

  always #5 clk = ~clk;

  // Program counter model: starts at 100, advances 4 per unheld cycle.
  always @(posedge clk) begin
    if (!reset_n)        pc <= 32'd100;
    else if (!fetch_hold) pc <= pc + 32'd4;
  end

  assign rf_rdata = rf[rf_raddr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [4:0] addr);
    req_cmd   = cmd;
    req_addr  = addr;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] data, input logic err);
    check({tag, " valid"}, 32'(resp_valid), 32'd1);
    check({tag, " data"}, resp_data, data);
    check({tag, " err"}, 32'(resp_err), 32'(err));
  endtask

  task automatic complete(input string tag);
    resp_ready = 1'b1;
    tick();
    check({tag, " done valid"}, 32'(resp_valid), 32'd0);
    check({tag, " done ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d1;
    for (int i = 0; i < 32; i++) rf[i] = (i >= 8) ? 32'((i - 7) * 4) : 32'(i);

    // Reset with a HALT request pending: nothing may be accepted.
    req_valid = 1'b1;
    req_cmd   = 3'b000;
    tick();
    tick();
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst fetch_hold", 32'(fetch_hold), 32'd0);
    check("rst rf_raddr", 32'(rf_raddr), 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    req_valid = 1'b0;
    reset_n   = 1'b1;

    // Run 14 cycles from PC 100, then HALT (PC 160 once fetch is held).
    repeat (14) tick();
    check("run fetch_hold", 32'(fetch_hold), 32'd0);
    issue(3'b000, 5'd0);
    check("halt fetch_hold", 32'(fetch_hold), 32'd1);
    check("halt req_ready", 32'(req_ready), 32'd0);
    check("halt early resp", 32'(resp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("drain%0d resp", i), 32'(resp_valid), 32'd0);
      check($sformatf("drain%0d hold", i), 32'(fetch_hold), 32'd1);
    end
    tick();
    expect_resp("halt", 32'd0, 1'b0);
    complete("halt");

    // Register reads 8..15, two cycles after acceptance.
    for (int i = 8; i <= 15; i++) begin
      issue(3'b011, 5'(i));
      check($sformatf("rdreg%0d raddr", i), 32'(rf_raddr), 32'(i));
      check($sformatf("rdreg%0d early", i), 32'(resp_valid), 32'd0);
      tick();
      expect_resp($sformatf("rdreg%0d", i), 32'((i - 7) * 4), 1'b0);
      complete("rdreg");
    end

    // PC is stable while halted.
    for (int i = 0; i < 2; i++) begin
      issue(3'b100, 5'd0);
      expect_resp($sformatf("rdpc%0d", i), 32'd160, 1'b0);
      complete("rdpc");
    end

    // HALT while halted: immediate, idempotent.
    issue(3'b000, 5'd0);
    expect_resp("halt2", 32'd0, 1'b0);
    check("halt2 hold", 32'(fetch_hold), 32'd1);
    complete("halt2");

    // Single step: one released fetch cycle, then drain, PC advanced by 4.
    issue(3'b010, 5'd0);
    check("step release", 32'(fetch_hold), 32'd0);
    check("step early", 32'(resp_valid), 32'd0);
    tick();
    check("step reclamp", 32'(fetch_hold), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sdrain%0d resp", i), 32'(resp_valid), 32'd0);
      check($sformatf("sdrain%0d hold", i), 32'(fetch_hold), 32'd1);
    end
    tick();
    expect_resp("step", 32'd164, 1'b0);
    complete("step");
    issue(3'b100, 5'd0);
    expect_resp("rdpc after step", 32'd164, 1'b0);
    complete("rdpc after step");

    // Resume.
    issue(3'b001, 5'd0);
    check("resume hold", 32'(fetch_hold), 32'd0);
    expect_resp("resume", 32'd0, 1'b0);
    complete("resume");

    // Read in RUN is refused without side effects.
    issue(3'b011, 5'd3);
    expect_resp("rdreg run", 32'd0, 1'b1);
    check("rdreg run raddr", 32'(rf_raddr), 32'd15);
    complete("rdreg run");
    check("rdreg run hold", 32'(fetch_hold), 32'd0);

    // Illegal command with response back-pressure and a queued request.
    resp_ready = 1'b0;
    issue(3'b111, 5'd0);
    expect_resp("illegal", 32'd0, 1'b1);
    req_cmd   = 3'b100;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_resp($sformatf("held%0d", i), 32'd0, 1'b1);
      check($sformatf("held%0d ready", i), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    check("overlap done valid", 32'(resp_valid), 32'd0);
    check("overlap ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    expect_resp("overlap rdpc run", 32'd0, 1'b1);
    check("overlap accepted", 32'(req_ready), 32'd0);
    complete("overlap");

    // STEP and RESUME in RUN.
    issue(3'b010, 5'd0);
    expect_resp("step run", 32'd0, 1'b1);
    complete("step run");
    check("step run hold", 32'(fetch_hold), 32'd0);
    issue(3'b001, 5'd0);
    expect_resp("resume run", 32'd0, 1'b0);
    complete("resume run");
    check("resume run hold", 32'(fetch_hold), 32'd0);

`ifdef PIPE_DEBUG_CYCLE_COUNTER_EN
    // Counter advances 10 across 10 cycles in RUN.
    issue(3'b101, 5'd0);
    check("cyc1 err", 32'(resp_err), 32'd0);
    d1 = resp_data;
    complete("cyc1");
    repeat (8) tick();
    issue(3'b101, 5'd0);
    check("cyc run diff", resp_data - d1, 32'd10);
    complete("cyc2");
    // Frozen while halted.
    issue(3'b000, 5'd0);
    repeat (5) tick();
    expect_resp("cyc halt", 32'd0, 1'b0);
    complete("cyc halt");
    issue(3'b101, 5'd0);
    d1 = resp_data;
    complete("cyc3");
    repeat (8) tick();
    issue(3'b101, 5'd0);
    check("cyc halted diff", resp_data - d1, 32'd0);
    complete("cyc4");
    issue(3'b001, 5'd0);
    complete("cyc resume");
`else
    issue(3'b101, 5'd0);
    expect_resp("rdcycle off", 32'd0, 1'b1);
    complete("rdcycle off");
`endif

    // Reset drops a pending response.
    resp_ready = 1'b0;
    issue(3'b100, 5'd0);
    check("pre-reset valid", 32'(resp_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    check("reset drop valid", 32'(resp_valid), 32'd0);
    check("reset drop ready", 32'(req_ready), 32'd1);
    check("reset drop err", 32'(resp_err), 32'd0);
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
